dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data_mem port between two requesters: the core MEM stage (single beats, read data needed in the same cycle) and a host/loader port (multi-beat bursts).
- Sits between the EXE-to-MEM pipeline register outputs and data_mem.
- Generates a core stall that the hazard unit ORs into its pipeline stall.
- Core has priority, but host starvation is bounded by a wait counter.

Parameters:
- WIDTH, 32, data width of all data buses.
- ADDR_WIDTH, 32, byte address width.
- MAX_BURST, 8, maximum host burst length in beats.
- STARVE_LIMIT, 4, number of host wait cycles after which the host wins over the core.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- core_req  in  1  MEM stage requests memory this cycle.
- core_we  in  1  core write enable.
- core_addr  in  ADDR_WIDTH  core byte address.
- core_wdata  in  WIDTH  core write data.
- core_gnt  out  1  core access performed this cycle.
- core_stall  out  1  core_req && !core_gnt.
- core_rdata  out  WIDTH  combinational passthrough of mem_rdata.
- host_req  in  1  host requests a burst.
- host_we  in  1  burst direction; 1 = write.
- host_addr  in  ADDR_WIDTH  burst start address.
- host_len  in  $clog2(MAX_BURST+1)  burst length in beats.
- host_wdata  in  WIDTH  write data for the current beat.
- host_gnt  out  1  host beat performed this cycle.
- host_rvalid  out  1  registered read-beat valid.
- host_rdata  out  WIDTH  registered read data.
- host_done  out  1  one-cycle pulse after the last beat.
- mem_we  out  1  to data_mem.
- mem_addr  out  ADDR_WIDTH  to data_mem.
- mem_wdata  out  WIDTH  to data_mem.
- mem_rdata  in  WIDTH  combinational read data from data_mem.

Behaviour:
- FSM states: IDLE and HOST_BURST.
- Registered state: host_wait_cnt (saturating at STARVE_LIMIT), beats_left, burst_addr, burst_we.
- Reset (rst low, asynchronous):
  - state = IDLE; all counters = 0.
  - host_rvalid = 0, host_done = 0, host_rdata = 0.
  - Combinational outputs evaluate to 0 while no request is present.
- Arbitration in IDLE (combinational, same cycle):
  - If host_req && host_wait_cnt == STARVE_LIMIT, the host wins.
  - Else if core_req, the core wins.
  - Else if host_req, the host wins.
- Core win:
  - core_gnt = 1.
  - mem_we/mem_addr/mem_wdata = core_we/core_addr/core_wdata.
  - State stays IDLE; zero added latency.
- Host win in IDLE:
  - Effective length L = host_len, with 0 treated as 1 and values > MAX_BURST clamped to MAX_BURST.
  - Beat 0 executes this cycle: host_gnt = 1, mem_addr = host_addr, mem_we = host_we, mem_wdata = host_wdata.
  - host_wait_cnt clears.
  - If L > 1: capture burst_addr = host_addr + 4, burst_we = host_we, beats_left = L-1, and move to HOST_BURST.
- HOST_BURST, each cycle:
  - host_gnt = 1; mem_addr = burst_addr; mem_we = burst_we; mem_wdata = host_wdata.
  - burst_addr += 4, wrapping modulo 2^ADDR_WIDTH; beats_left decrements.
  - When beats_left == 1 on this beat, return to IDLE.
  - host_req and host_addr/host_len are ignored; a burst cannot be aborted.
  - core_gnt = 0, so any core_req sees core_stall = 1.
- Host read beats: for every granted read beat, the cycle after it has host_rvalid = 1 and host_rdata = mem_rdata as sampled at that beat.
- host_done: registered; high exactly one cycle after the final beat, coincident with the final host_rvalid for reads.
- host_wait_cnt: increments each cycle host_req && !host_gnt, saturating at STARVE_LIMIT.
- Idle bus: when there is no grant, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Worst-case core stall: MAX_BURST cycles per host burst. The host waits at most STARVE_LIMIT cycles before winning.
- Reset asserted mid-burst: the burst is abandoned, no host_done is generated, and there are no further writes.
- Simultaneous core_req and host_req with host_wait_cnt < STARVE_LIMIT: the core wins and host_wait_cnt increments.

Test Plan:
- Core-only: core write 0xDEADBEEF to 0x100, then core read 0x100 → core_gnt = 1 both cycles, core_stall = 0, core_rdata = 0xDEADBEEF in the read cycle.
- Host write burst: host_addr = 0x200, host_len = 4, host_wdata 1..4 → mem_addr 0x200/0x204/0x208/0x20C on 4 consecutive cycles, host_gnt = 1 throughout, host_done pulses in cycle 5; a core_req held throughout sees core_stall = 1 for exactly those 4 cycles.
- Host read burst, host_len = 3 from 0x200 → host_rvalid high cycles 2-4 with data 1, 2, 3; host_done in cycle 4.
- Starvation: core_req and host_req held continuously, STARVE_LIMIT = 4 → core granted cycles 1-4, host granted cycle 5, host_wait_cnt back to 0.
- Boundaries:
  - host_len = 0 → exactly one beat.
  - host_len = 15 → 8 beats.
  - host_addr = 0xFFFFFFFC with len 2 → second beat at 0x00000000.
- Assert rst low after beat 2 of a 6-beat write → outputs clear immediately, no host_done, mem_we = 0 after release until a new grant.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and data_mem signals around the data-memory arbiter.
// Handshake: a requester holds *_req; an access happens in exactly the cycle its *_gnt is high.
interface dmem_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [WIDTH-1:0]      core_wdata;
  logic                  core_gnt;
  logic                  core_stall;
  logic [WIDTH-1:0]      core_rdata;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [LEN_W-1:0]      host_len;
  logic [WIDTH-1:0]      host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [WIDTH-1:0]      host_rdata;
  logic                  host_done;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  // Environment side: requesters and the memory's read data.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_len, host_wdata,
    output mem_rdata,
    input  core_gnt, core_stall, core_rdata,
    input  host_gnt, host_rvalid, host_rdata, host_done,
    input  mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    input  mem_rdata,
    output core_gnt, core_stall, core_rdata,
    output host_gnt, host_rvalid, host_rdata, host_done,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data_mem port between the MEM stage (single beats, priority) and a
// host burst port; starvation of the host is bounded by a saturating wait counter.
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           dbg_state
);
  localparam int LEN_W  = $clog2(MAX_BURST + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE = 1'b0, HOST_BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0]      beats_left_q, beats_left_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic                  burst_we_q, burst_we_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [WIDTH-1:0]      host_rdata_q, host_rdata_d;
  logic                  host_done_q, host_done_d;

  logic                  core_gnt, host_gnt, last_beat, host_win, starved;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [LEN_W-1:0]      eff_len;

  // A zero length still moves one beat; oversize requests are clamped.
  assign eff_len = (bus.host_len == '0)                  ? LEN_W'(1) :
                   (bus.host_len > LEN_W'(MAX_BURST))    ? LEN_W'(MAX_BURST) :
                                                           bus.host_len;
  assign starved  = (wait_cnt_q == WAIT_W'(STARVE_LIMIT));
  assign host_win = bus.host_req && (starved || !bus.core_req);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    beats_left_d = beats_left_q;
    burst_addr_d = burst_addr_q;
    burst_we_d   = burst_we_q;
    core_gnt     = 1'b0;
    host_gnt     = 1'b0;
    last_beat    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (host_win) begin
          host_gnt   = 1'b1;
          mem_we     = bus.host_we;
          mem_addr   = bus.host_addr;
          mem_wdata  = bus.host_wdata;
          wait_cnt_d = '0;
          if (eff_len > LEN_W'(1)) begin
            burst_addr_d = bus.host_addr + ADDR_WIDTH'(4);
            burst_we_d   = bus.host_we;
            beats_left_d = eff_len - LEN_W'(1);
            state_d      = HOST_BURST;
          end else begin
            last_beat = 1'b1;
          end
        end else begin
          if (bus.core_req) begin
            core_gnt  = 1'b1;
            mem_we    = bus.core_we;
            mem_addr  = bus.core_addr;
            mem_wdata = bus.core_wdata;
          end
          if (bus.host_req && !starved) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HOST_BURST: begin
        // Burst cannot be aborted; host_req/addr/len are not looked at here.
        host_gnt     = 1'b1;
        mem_we       = burst_we_q;
        mem_addr     = burst_addr_q;
        mem_wdata    = bus.host_wdata;
        burst_addr_d = burst_addr_q + ADDR_WIDTH'(4);
        beats_left_d = beats_left_q - LEN_W'(1);
        if (beats_left_q == LEN_W'(1)) begin
          state_d   = IDLE;
          last_beat = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign host_rvalid_d = host_gnt && !mem_we;
  assign host_rdata_d  = host_rvalid_d ? bus.mem_rdata : host_rdata_q;
  assign host_done_d   = last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      beats_left_q  <= '0;
      burst_addr_q  <= '0;
      burst_we_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      beats_left_q  <= beats_left_d;
      burst_addr_q  <= burst_addr_d;
      burst_we_q    <= burst_we_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_done_q   <= host_done_d;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.core_stall  = bus.core_req && !core_gnt;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_done   = host_done_q;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign dbg_state       = (state_q == HOST_BURST);
endmodule
